// File: rtl/mix_i2s_out.sv
// Mixer sum -> signed 16-bit PCM (DC removal, gain shift, saturate) -> mono Philips I2S; 2-clk datapath latency.
// Free-running with no backpressure: one word is latched per 64-bit frame and sent in both slots.
module mix_i2s_out #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] mixed_signal,
  input  logic [2:0]  gain_shift,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sample_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic signed [19:0] PCM_MAX = 20'sd32767;
  localparam logic signed [19:0] PCM_MIN = -20'sd32768;

  logic [19:0]        in_q;
  logic [15:0]        pcm_q;
  logic [15:0]        shreg;
  logic [DW-1:0]      div_cnt;
  logic [5:0]         bit_cnt;
  logic [5:0]         bit_nxt;
  logic [4:0]         pos;
  logic [3:0]         sidx;
  logic               fall_evt;
  logic               wrap;
  logic               sdata_nxt;
  logic [2:0]         shamt;
  logic signed [19:0] centred;
  logic signed [19:0] shifted;
  logic [15:0]        pcm_nxt;

  // Flipping the MSB of the offset-binary sum is the same as subtracting 0x80000.
  always_comb begin
    centred = signed'({~in_q[19], in_q[18:0]});
    shamt   = (gain_shift > 3'd4) ? 3'd4 : gain_shift;
    shifted = centred >>> shamt;
    if (shifted > PCM_MAX)
      pcm_nxt = 16'h7FFF;
    else if (shifted < PCM_MIN)
      pcm_nxt = 16'h8000;
    else
      pcm_nxt = shifted[15:0];
  end

  always_comb begin
    fall_evt  = (div_cnt == DIV_LAST) && bclk;
    wrap      = fall_evt && (bit_cnt == 6'd63);
    bit_nxt   = bit_cnt + 6'd1;
    pos       = bit_nxt[4:0];
    sidx      = 4'(5'd16 - pos);
    // Slot position 0 is the one-BCLK I2S delay; positions 17..31 are padding.
    sdata_nxt = (pos != 5'd0 && pos <= 5'd16) ? shreg[sidx] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      pcm_q <= '0;
    end else begin
      in_q  <= mixed_signal;
      pcm_q <= pcm_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      shreg       <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= wrap;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[5];
        sdata   <= sdata_nxt;
      end
      if (wrap)
        shreg <= mute ? 16'h0000 : pcm_q;
    end
  end

endmodule
